// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control and status bundle between a clk_div_prog and its user.
interface clk_div_prog_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic [CNT_W-1:0] div_value;
    logic             div_load;
    logic             div_ack;
    logic             div_err;
    logic             clk_out;
    logic             tick;
    logic             active;
    modport master (output enable, div_value, div_load, input div_ack, div_err, clk_out, tick, active);
    modport slave (input enable, div_value, div_load, output div_ack, div_err, clk_out, tick, active);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider with load handshake and period tick.
// Define CLKDIV_EXACT_DUTY_EN for a 50% duty output on odd ratios (adds one negedge flop).
module clk_div_prog #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 50
) (
    input logic           clk_in,
    input logic           rst_n,
    clk_div_prog_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, n_cur, n_nx, pend, pend_nx;
    logic [CNT_W:0]   half;
    logic             pend_vld, pend_vld_nx, phase, phase_nx, ack_q, err_q;
    logic             load_ok, load_bad, wrap, boundary, apply;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            n_cur    <= CNT_W'(DEFAULT_DIV);
            pend     <= '0;
            pend_vld <= 1'b0;
            phase    <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            n_cur    <= n_nx;
            pend     <= pend_nx;
            pend_vld <= pend_vld_nx;
            phase    <= phase_nx;
            ack_q    <= apply;
            err_q    <= load_bad;
        end
    end

    // A rejected load at a boundary holds any pending ratio one more period so ack and err never coincide.
    always_comb begin
        load_ok     = bus.div_load && bus.div_value >= CNT_W'(2);
        load_bad    = bus.div_load && !load_ok;
        wrap        = state == RUN && cnt == n_cur - CNT_W'(1);
        boundary    = state == IDLE || wrap;
        apply       = boundary && !load_bad && (load_ok || pend_vld);
        n_nx        = apply ? (load_ok ? bus.div_value : pend) : n_cur;
        pend_nx     = load_ok ? bus.div_value : pend;
        pend_vld_nx = apply ? 1'b0 : (pend_vld || load_ok);
        state_nx    = boundary ? (bus.enable ? RUN : IDLE) : state;
        cnt_nx      = boundary ? '0 : cnt + CNT_W'(1);
        half        = ({1'b0, n_nx} + (CNT_W+1)'(1)) >> 1;
        phase_nx    = state_nx == RUN && {1'b0, cnt_nx} < half;
    end

`ifdef CLKDIV_EXACT_DUTY_EN
    logic phase_neg;
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) phase_neg <= 1'b0;
        else        phase_neg <= phase;
    end
`endif

    always_comb begin
        bus.tick    = wrap;
        bus.active  = state == RUN;
        bus.div_ack = ack_q;
        bus.div_err = err_q;
`ifdef CLKDIV_EXACT_DUTY_EN
        bus.clk_out = n_cur[0] ? (phase & phase_neg) : phase;
`else
        bus.clk_out = phase;
`endif
    end
endmodule
